// File: rtl/m_pixel_fifo_pkg.sv
// Shared pixel definitions: screen geometry, field widths and the packed
// {x,y,color} word stored in the pixel FIFO.
package m_pixel_fifo_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOR_W  = 12;
   localparam int PIX_W    = X_W + Y_W + COLOR_W;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

   // True when the coordinate lies on the visible screen.
   function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
   endfunction

endpackage

// File: rtl/m_pixel_fifo_if.sv
// Pixel FIFO bus: renderer write side, VGA adapter plot side and status.
// master = renderer/adapter/test side, slave = the FIFO itself.
interface m_pixel_fifo_if #(
   parameter int DEPTH = 16
);
   import m_pixel_fifo_pkg::*;

   logic                     flush;
   logic                     in_valid;
   logic [X_W-1:0]           in_x;
   logic [Y_W-1:0]           in_y;
   logic [COLOR_W-1:0]       in_color;
   logic                     in_ready;
   logic                     out_ready;
   logic [X_W-1:0]           VGA_X;
   logic [Y_W-1:0]           VGA_Y;
   logic [COLOR_W-1:0]       VGA_COLOR;
   logic                     VGA_PLOT;
   logic                     overflow;
   logic [$clog2(DEPTH):0]   level;

   modport master (
      output flush, in_valid, in_x, in_y, in_color, out_ready,
      input  in_ready, VGA_X, VGA_Y, VGA_COLOR, VGA_PLOT, overflow, level
   );

   modport slave (
      input  flush, in_valid, in_x, in_y, in_color, out_ready,
      output in_ready, VGA_X, VGA_Y, VGA_COLOR, VGA_PLOT, overflow, level
   );

endinterface

// File: rtl/m_pixel_fifo_ram.sv
// DEPTH x pixel simple dual-port RAM with a registered read port.
// The read register only loads on re_i, so it also serves as the
// hold-last-value VGA output stage of the FIFO.
module m_pixel_fifo_ram
   import m_pixel_fifo_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  pixel_t                   wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output pixel_t                   rdata_o
);

   pixel_t mem_q [DEPTH];
   pixel_t rdata_q;

   // Write port: storage array, no reset so it can map to block RAM.
   always_ff @(posedge clock) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Read port: registered, loads only on a pop and holds otherwise.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)   rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/m_pixel_fifo.sv
// Elastic pixel-write buffer between the renderer and the VGA write port.
// Optional build macro PIXEL_CLIP_EN: off-screen writes are discarded at
// the input without consuming an entry or setting overflow.
module m_pixel_fifo
   import m_pixel_fifo_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int AFULL_MARGIN = 3
) (
   input  logic         clock,
   input  logic         resetn,
   m_pixel_fifo_if.slave pix
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          in_ready_q, in_ready_d;
   logic          plot_q, plot_d;

   logic   full, empty, accept, push, pop;
   pixel_t wdata, rdata;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

`ifdef PIXEL_CLIP_EN
   assign accept = pix.in_valid && on_screen(pix.in_x, pix.in_y);
`else
   assign accept = pix.in_valid;
`endif

   // Flush wins over both ports; full is judged on the pre-edge count.
   assign push = accept && !full && !pix.flush;
   assign pop  = pix.out_ready && !empty && !pix.flush;

   assign wdata = '{x: pix.in_x, y: pix.in_y, color: pix.in_color};

   // Next-state for pointers, occupancy, sticky overflow, throttle and strobe.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      plot_d     = 1'b0;
      if (pix.flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (accept && full) overflow_d = 1'b1;
         plot_d = pop;
      end
      // Throttle follows the new occupancy so it drops in the same cycle level hits the mark.
      in_ready_d = (count_d < CW'(DEPTH - AFULL_MARGIN));
   end

   // State registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         in_ready_q <= 1'b0;
         plot_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         in_ready_q <= in_ready_d;
         plot_q     <= plot_d;
      end
   end

   m_pixel_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clock   (clock),
      .resetn  (resetn),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .re_i    (pop),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   assign pix.VGA_X     = rdata.x;
   assign pix.VGA_Y     = rdata.y;
   assign pix.VGA_COLOR = rdata.color;
   assign pix.VGA_PLOT  = plot_q;
   assign pix.overflow  = overflow_q;
   assign pix.in_ready  = in_ready_q;
   assign pix.level     = count_q;

endmodule

// File: tb/tb_m_pixel_fifo.sv
// Self-checking bench for m_pixel_fifo: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_m_pixel_fifo;

   localparam int DEPTH = 16;
   localparam int MARGIN = 3;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   failures = 0;

   m_pixel_fifo_if #(.DEPTH(DEPTH)) bus ();

   m_pixel_fifo #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
      .clock  (clock),
      .resetn (resetn),
      .pix    (bus)
   );

   always #5 clock = ~clock;

   // reference model state
   logic [26:0] mq[$];
   logic [26:0] m_vga = '0;
   logic        m_plot = 1'b0;
   logic        m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input int x, input int y);
`ifdef PIXEL_CLIP_EN
      return (x < 160) && (y < 120);
`else
      return 1'b1;
`endif
   endfunction

   // one clock: drive, advance model at the edge, compare 1 time unit later
   task automatic step(input bit v, input int x, input int y, input int c,
                       input bit ordy, input bit fl);
      bit acc, was_full;
      bus.in_valid  = v;
      bus.in_x      = 8'(x);
      bus.in_y      = 7'(y);
      bus.in_color  = 12'(c);
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(posedge clock);
      acc      = v && in_range(x, y);
      was_full = (mq.size() == DEPTH);
      if (fl) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_plot = 1'b0;
      end else begin
         m_plot = ordy && (mq.size() != 0);
         if (m_plot) m_vga = mq.pop_front();
         if (acc && !was_full) mq.push_back({8'(x), 7'(y), 12'(c)});
         if (acc && was_full) m_ovf = 1'b1;
      end
      #1;
      chk("level",    32'(bus.level), 32'(mq.size()));
      chk("plot",     32'(bus.VGA_PLOT), 32'(m_plot));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH - MARGIN));
      chk("vga_pix",  32'({bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}), 32'(m_vga));
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, 0, 0, 0, ordy, 1'b0);
   endtask

   initial begin
      bus.flush = 0; bus.in_valid = 0; bus.in_x = '0; bus.in_y = '0;
      bus.in_color = '0; bus.out_ready = 0;

      // reset state
      #12;
      chk("rst_level",    32'(bus.level), 0);
      chk("rst_plot",     32'(bus.VGA_PLOT), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_vga",      32'({bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}), 0);
      #8 resetn = 1'b1;

      // single write: plot appears two edges later
      step(1'b1, 5, 7, 12'hFFF, 1'b1, 1'b0);
      chk("t1_plot_e1", 32'(bus.VGA_PLOT), 0);
      idle(1'b1);
      chk("t1_plot_e2", 32'(bus.VGA_PLOT), 1);
      chk("t1_x", 32'(bus.VGA_X), 5);
      chk("t1_y", 32'(bus.VGA_Y), 7);
      chk("t1_c", 32'(bus.VGA_COLOR), 32'hFFF);
      chk("t1_level", 32'(bus.level), 0);
      idle(1'b1);

      // fill with adapter stalled, then one more write overflows
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 4095), 1'b0, 1'b0);
         if (i == 11) chk("t2_in_ready_12", 32'(bus.in_ready), 1);
         if (i == 12) chk("t2_in_ready_13", 32'(bus.in_ready), 0);
      end
      chk("t2_level_full", 32'(bus.level), DEPTH);
      chk("t2_no_ovf_yet", 32'(bus.overflow), 0);
      step(1'b1, 1, 1, 1, 1'b0, 1'b0);
      chk("t2_overflow", 32'(bus.overflow), 1);
      chk("t2_level", 32'(bus.level), DEPTH);

      // full: pop and write together, write is still rejected
      step(1'b1, 2, 2, 2, 1'b1, 1'b0);
      chk("t3_level", 32'(bus.level), DEPTH - 1);
      chk("t3_plot", 32'(bus.VGA_PLOT), 1);

      // drain to 8, then 20 cycles of simultaneous write and pop
      for (int i = 0; i < 7; i++) idle(1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 4095), 1'b1, 1'b0);
         chk("t4_level", 32'(bus.level), 8);
      end

      // flush at level 6 alongside a write
      idle(1'b1); idle(1'b1);
      chk("t5_pre_level", 32'(bus.level), 6);
      step(1'b1, 9, 9, 9, 1'b1, 1'b1);
      chk("t5_level", 32'(bus.level), 0);
      chk("t5_overflow", 32'(bus.overflow), 0);
      chk("t5_plot", 32'(bus.VGA_PLOT), 0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         chk("t5_no_stale", 32'(bus.VGA_PLOT), 0);
      end

      // off-screen coordinates
      step(1'b1, 160, 0, 12'h123, 1'b1, 1'b0);
      step(1'b1, 0, 120, 12'h456, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
`ifdef PIXEL_CLIP_EN
      chk("t6_level", 32'(bus.level), 0);
`endif

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 170), $urandom_range(0, 125),
              $urandom_range(0, 4095), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
      chk("end_level", 32'(bus.level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
